// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
// Parallel-in, serial-out shift register. A WIDTH-bit word is taken through a
// valid/ready load handshake and sent one bit per enabled clock on data_out,
// with frame markers so a downstream deserializer can be driven directly.
// Back-to-back words are sent with no idle gap.
//
// Configuration macro:
//   PISO_PARITY_EN  - when defined, an even-parity bit (XOR of the captured
//                     word) is appended as the final bit of every frame and
//                     frame_last moves onto it.
//
// Parameters:
//   WIDTH      bits per word (2..32)
//   MSB_FIRST  1: bit WIDTH-1 is sent first, 0: bit 0 is sent first
//
// Ports:
//   clk          system clock, rising edge active
//   rst          asynchronous active-low reset
//   data_in      parallel word to serialize
//   load_valid   data_in is valid this cycle
//   load_ready   serializer can accept a word this cycle
//   shift_en     advance the serial stream this cycle (low stalls)
//   data_out     current serial bit (register output)
//   out_valid    data_out carries a frame bit
//   frame_start  first bit of a frame is presented
//   frame_last   final bit of a frame is presented
// -----------------------------------------------------------------------------
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             data_out,
    output logic             out_valid,
    output logic             frame_start,
    output logic             frame_last
);

`ifdef PISO_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t               state_r;
    state_t               next_state_s;
    // Frame bits are held in transmit order: the bit on the wire is always
    // the top of this register, and each shift moves the next bit up.
    logic [FRAME_LEN-1:0] shift_r;
    logic [FRAME_LEN-1:0] next_shift_s;
    logic [FRAME_LEN-1:0] frame_load_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [CNT_W-1:0]     next_cnt_s;
    logic                 frame_start_r;
    logic                 frame_last_r;
    logic                 last_s;
    logic                 load_ready_s;
    logic                 accept_s;

    // Put the word into transmit order so the shifter never needs to know
    // which end goes first.
    function automatic logic [WIDTH-1:0] order_bits(input logic [WIDTH-1:0] w);
        logic [WIDTH-1:0] r;
        r = w;
        if (MSB_FIRST) begin
            r = w;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                r[i] = w[WIDTH-1-i];
            end
        end
        return r;
    endfunction

`ifdef PISO_PARITY_EN
    // Even parity: the appended bit makes the total count of ones even.
    function automatic logic parity_even(input logic [WIDTH-1:0] w);
        return ^w;
    endfunction

    assign frame_load_s = {order_bits(data_in), parity_even(data_in)};
`else
    assign frame_load_s = order_bits(data_in);
`endif

    assign last_s   = (cnt_r == LAST_CNT);
    assign accept_s = load_valid && load_ready_s;

    // Load handshake: always open in IDLE; in SHIFT only on a final bit that
    // is actually leaving this cycle, so a stalled final bit blocks loading.
    always_comb begin
        load_ready_s = 1'b0;
        case (state_r)
            IDLE:    load_ready_s = 1'b1;
            SHIFT:   load_ready_s = last_s && shift_en;
            default: load_ready_s = 1'b0;
        endcase
    end

    // Next-state, next shift contents and next bit count.
    always_comb begin
        next_state_s = state_r;
        next_shift_s = shift_r;
        next_cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    next_state_s = SHIFT;
                    next_shift_s = frame_load_s;
                    next_cnt_s   = {CNT_W{1'b0}};
                end else begin
                    next_state_s = IDLE;
                end
            end
            SHIFT: begin
                if (!shift_en) begin
                    next_state_s = SHIFT;
                end else if (!last_s) begin
                    next_shift_s = {shift_r[FRAME_LEN-2:0], 1'b0};
                    next_cnt_s   = cnt_r + CNT_ONE;
                end else if (load_valid) begin
                    // Zero-gap chaining into the next word.
                    next_state_s = SHIFT;
                    next_shift_s = frame_load_s;
                    next_cnt_s   = {CNT_W{1'b0}};
                end else begin
                    // Clearing the shifter keeps data_out low while idle.
                    next_state_s = IDLE;
                    next_shift_s = {FRAME_LEN{1'b0}};
                    next_cnt_s   = {CNT_W{1'b0}};
                end
            end
            default: begin
                next_state_s = IDLE;
                next_shift_s = {FRAME_LEN{1'b0}};
                next_cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, shifter, counter and frame-marker registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= IDLE;
            shift_r       <= {FRAME_LEN{1'b0}};
            cnt_r         <= {CNT_W{1'b0}};
            frame_start_r <= 1'b0;
            frame_last_r  <= 1'b0;
        end else begin
            state_r       <= next_state_s;
            shift_r       <= next_shift_s;
            cnt_r         <= next_cnt_s;
            frame_start_r <= (next_state_s == SHIFT) && (next_cnt_s == {CNT_W{1'b0}});
            frame_last_r  <= (next_state_s == SHIFT) && (next_cnt_s == LAST_CNT);
        end
    end

    assign data_out    = shift_r[FRAME_LEN-1];
    assign out_valid   = (state_r == SHIFT);
    assign frame_start = frame_start_r;
    assign frame_last  = frame_last_r;
    assign load_ready  = load_ready_s;

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
// Drives an MSB-first and an LSB-first serializer with identical stimulus.
// A word-level model (busy flag, current word, bit index) predicts every
// output each cycle; directed sequences pin the expected serial streams with
// literal values.
// -----------------------------------------------------------------------------
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
    localparam int FLEN = 5;
`else
    localparam int FLEN = 4;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] din;
    logic       lv;
    logic       se;

    logic m_ready, m_dout, m_valid, m_fs, m_fl;
    logic l_ready, l_dout, l_valid, l_fs, l_fl;

    int n_pass  = 0;
    int n_total = 0;

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .data_in(din), .load_valid(lv),
        .load_ready(m_ready), .shift_en(se), .data_out(m_dout),
        .out_valid(m_valid), .frame_start(m_fs), .frame_last(m_fl)
    );

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .data_in(din), .load_valid(lv),
        .load_ready(l_ready), .shift_en(se), .data_out(l_dout),
        .out_valid(l_valid), .frame_start(l_fs), .frame_last(l_fl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- word-level model ----------------
    logic       busy_m = 1'b0;
    int         idx_m  = 0;
    logic [3:0] word_m = 4'd0;

    function automatic logic exp_bit(input bit msb, input logic [3:0] w, input int idx);
        if (idx >= 4) return ^w;
        else if (msb) return w[3-idx];
        else return w[idx];
    endfunction

    function automatic logic exp_ready();
        return !busy_m || ((idx_m == FLEN - 1) && se);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_m <= 1'b0;
            idx_m  <= 0;
            word_m <= 4'd0;
        end else begin
            if (busy_m && se) begin
                if (idx_m == FLEN - 1) busy_m <= 1'b0;
                else idx_m <= idx_m + 1;
            end
            if (lv && exp_ready()) begin
                busy_m <= 1'b1;
                idx_m  <= 0;
                word_m <= din;
            end
        end
    end

    // Per-cycle comparison of both DUTs against the model.
    always @(negedge clk) begin
        chk("valid_m", {31'd0, m_valid}, {31'd0, busy_m});
        chk("valid_l", {31'd0, l_valid}, {31'd0, busy_m});
        chk("dout_m", {31'd0, m_dout}, {31'd0, busy_m && exp_bit(1'b1, word_m, idx_m)});
        chk("dout_l", {31'd0, l_dout}, {31'd0, busy_m && exp_bit(1'b0, word_m, idx_m)});
        chk("start_m", {31'd0, m_fs}, {31'd0, busy_m && (idx_m == 0)});
        chk("start_l", {31'd0, l_fs}, {31'd0, busy_m && (idx_m == 0)});
        chk("last_m", {31'd0, m_fl}, {31'd0, busy_m && (idx_m == FLEN - 1)});
        chk("last_l", {31'd0, l_fl}, {31'd0, busy_m && (idx_m == FLEN - 1)});
        chk("ready_m", {31'd0, m_ready}, {31'd0, exp_ready()});
        chk("ready_l", {31'd0, l_ready}, {31'd0, exp_ready()});
    end

    // ---------------- directed helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Present a word for exactly one accepting edge (DUT must be idle).
    task automatic load_word(input logic [3:0] w);
        din = w;
        lv  = 1'b1;
        se  = 1'b1;
        tick();
        lv  = 1'b0;
    endtask

    // Capture n cycles of outputs, cycle 1 ending up as the most significant
    // bit. shift_en is low for cycles st_from..st_to; load_valid drops after
    // cycle lv_off (0 = leave alone).
    task automatic capture(input int n, input int lv_off, input int st_from, input int st_to,
                           output logic [15:0] sm, output logic [15:0] sl,
                           output logic [15:0] rdy, output logic [15:0] fs,
                           output logic [15:0] fl);
        sm = 16'd0; sl = 16'd0; rdy = 16'd0; fs = 16'd0; fl = 16'd0;
        for (int k = 1; k <= n; k++) begin
            se = (k >= st_from && k <= st_to) ? 1'b0 : 1'b1;
            @(negedge clk);
            sm  = {sm[14:0], m_dout};
            sl  = {sl[14:0], l_dout};
            rdy = {rdy[14:0], m_ready};
            fs  = {fs[14:0], m_fs};
            fl  = {fl[14:0], m_fl};
            tick();
            if (k == lv_off) lv = 1'b0;
        end
        se = 1'b1;
    endtask

    logic [15:0] sm, sl, rdy, fs, fl;

    initial begin
        rst = 1'b0; din = 4'd0; lv = 1'b0; se = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_dout", {31'd0, m_dout}, 32'd0);
        chk("rst_ready", {31'd0, m_ready}, 32'd1);
        rst = 1'b1;
        tick();

        // Single word, MSB first.
        load_word(4'b1001);
        capture(FLEN, 0, 0, 0, sm, sl, rdy, fs, fl);
`ifdef PISO_PARITY_EN
        chk("single_stream", {16'd0, sm}, 32'b10010);
        chk("single_start", {16'd0, fs}, 32'b10000);
        chk("single_last", {16'd0, fl}, 32'b00001);
`else
        chk("single_stream", {16'd0, sm}, 32'b1001);
        chk("single_start", {16'd0, fs}, 32'b1000);
        chk("single_last", {16'd0, fl}, 32'b0001);
`endif
        @(negedge clk);
        chk("single_idle_valid", {31'd0, m_valid}, 32'd0);
        chk("single_idle_ready", {31'd0, m_ready}, 32'd1);
        tick();

        // LSB-first ordering.
        load_word(4'b1101);
        capture(FLEN, 0, 0, 0, sm, sl, rdy, fs, fl);
`ifdef PISO_PARITY_EN
        chk("lsb_stream", {16'd0, sl}, 32'b10111);
        chk("msb_stream_1101", {16'd0, sm}, 32'b11011);
`else
        chk("lsb_stream", {16'd0, sl}, 32'b1011);
        chk("msb_stream_1101", {16'd0, sm}, 32'b1101);
`endif
        tick();

        // Back-to-back words with load_valid held.
        load_word(4'b1001);
        din = 4'b0110;
        lv  = 1'b1;
        capture(2 * FLEN, FLEN, 0, 0, sm, sl, rdy, fs, fl);
`ifdef PISO_PARITY_EN
        chk("b2b_stream", {16'd0, sm}, 32'b1001001100);
        chk("b2b_ready", {16'd0, rdy}, 32'b0000100001);
        chk("b2b_start", {16'd0, fs}, 32'b1000010000);
`else
        chk("b2b_stream", {16'd0, sm}, 32'b10010110);
        chk("b2b_ready", {16'd0, rdy}, 32'b00010001);
        chk("b2b_start", {16'd0, fs}, 32'b10001000);
`endif
        tick();

        // Stall for 3 cycles on the second bit.
        load_word(4'b1011);
        capture(FLEN + 3, 0, 2, 4, sm, sl, rdy, fs, fl);
`ifdef PISO_PARITY_EN
        chk("stall_stream", {16'd0, sm}, 32'b10000111);
        chk("stall_ready", {16'd0, rdy}, 32'b00000001);
        chk("stall_last", {16'd0, fl}, 32'b00000001);
`else
        chk("stall_stream", {16'd0, sm}, 32'b1000011);
        chk("stall_ready", {16'd0, rdy}, 32'b0000001);
        chk("stall_last", {16'd0, fl}, 32'b0000001);
`endif
        tick();

        // Asynchronous reset in the middle of a frame.
        load_word(4'b1111);
        capture(2, 0, 0, 0, sm, sl, rdy, fs, fl);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, m_valid}, 32'd0);
        chk("mid_rst_dout_m", {31'd0, m_dout}, 32'd0);
        chk("mid_rst_dout_l", {31'd0, l_dout}, 32'd0);
        chk("mid_rst_marks", {30'd0, m_fs, m_fl}, 32'd0);
        chk("mid_rst_ready", {31'd0, m_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        tick();
        load_word(4'b0001);
        capture(FLEN, 0, 0, 0, sm, sl, rdy, fs, fl);
`ifdef PISO_PARITY_EN
        chk("post_rst_stream", {16'd0, sm}, 32'b00011);
`else
        chk("post_rst_stream", {16'd0, sm}, 32'b0001);
`endif
        tick();

        // Randomized traffic checked by the per-cycle comparison.
        for (int c = 0; c < 3000; c++) begin
            din = 4'($urandom);
            lv  = ($urandom_range(0, 2) != 0);
            se  = ($urandom_range(0, 3) != 0);
            tick();
        end
        lv = 1'b0;
        se = 1'b1;
        repeat (FLEN + 2) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out shift register. The transmit-side counterpart of the team's 4-bit SIPO deserializer.
- Accepts a WIDTH-bit word through a valid/ready load handshake and emits it one bit per enabled clock on data_out.
- Frame markers are provided so a downstream SIPO can be driven and checked directly.
- Supports back-to-back words with no idle gap.

Parameters:
- WIDTH, 4: bits per word; legal range 2 to 32.
- MSB_FIRST, 1: 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.

Ports:
- clk  input  1  system clock; rising edge active.
- rst  input  1  asynchronous, active-low reset.
- data_in  input  WIDTH  parallel word to serialize.
- load_valid  input  1  data_in is valid this cycle.
- load_ready  output  1  serializer can accept a word this cycle.
- shift_en  input  1  advance the serial stream this cycle; low stalls it.
- data_out  output  1  current serial bit.
- out_valid  output  1  data_out carries a frame bit.
- frame_start  output  1  high while the first bit of a frame is presented.
- frame_last  output  1  high while the final bit of a frame is presented.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, shift register 0, bit counter 0.
  - Outputs: data_out=0, out_valid=0, frame_start=0, frame_last=0, load_ready=1.
  - Releasing reset mid-frame discards the partial word; nothing resumes.
- Accept: a word is accepted on a rising edge where load_valid && load_ready.
  - data_in is captured into the shift register and the counter clears.
- FSM states: IDLE and SHIFT.
- IDLE:
  - load_ready=1, out_valid=0, data_out=0.
  - On accept: go to SHIFT.
  - The first bit appears on data_out in the next cycle, with out_valid=1 and frame_start=1. Latency from accept edge to first bit is 1 cycle.
- SHIFT:
  - data_out shows the current bit, registered (no combinational path from data_in).
  - Edge with shift_en=1 and bit not final: shift, counter+1. frame_start drops after the first bit.
  - Edge with shift_en=0: hold data_out, counter and all markers unchanged. out_valid stays 1.
- Final bit (counter == frame length − 1):
  - frame_last=1.
  - load_ready = shift_en. Outside this cycle, load_ready=0 in SHIFT.
- Final edge with shift_en=1:
  - If load_valid: accept the new word and stay in SHIFT. The new frame's first bit follows with zero gap; frame_start=1 and frame_last=0.
  - Else: return to IDLE, out_valid=0.
- Bit order:
  - MSB_FIRST=1: bits WIDTH-1 down to 0.
  - MSB_FIRST=0: bits 0 up to WIDTH-1.
- Counter width: clog2 of frame length. No wrap except the explicit clear on accept.
- Simultaneous events:
  - load_valid while load_ready=0 is ignored; data_in is not sampled.
  - A stall on the final bit blocks acceptance.
- Frame length is WIDTH, or WIDTH+1 with the optional feature.
- Every bit occupies at least one clock; a frame occupies exactly (frame length + stalled cycles) clocks.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of the captured word) is appended as bit WIDTH+1 of the frame.
  - frame_last moves to the parity bit.
  - Parity is computed at accept time from the captured word.
- Undefined: frame is WIDTH bits and no parity logic is generated.

Test Plan:
- Reset then single word: rst low 2 cycles, release; WIDTH=4, MSB_FIRST=1, data_in=4'b1001 with load_valid for 1 cycle, shift_en=1.
  - data_out = 1,0,0,1 on the 4 cycles after accept.
  - frame_start on cycle 1, frame_last on cycle 4.
  - out_valid=0 and load_ready=1 on cycle 5.
- Back-to-back: 4'b1001 then 4'b0110, load_valid held high.
  - Serial stream 1,0,0,1,0,1,1,0 with out_valid high 8 continuous cycles.
  - load_ready high only on cycles 4 and 8.
- Stall: shift_en=0 for 3 cycles while bit 2 of 4'b1011 is presented.
  - data_out holds 0 for 4 cycles, then continues 1,1.
  - Total frame is 7 cycles; load_ready stays 0 throughout the stall.
- LSB-first: MSB_FIRST=0, data_in=4'b1101 → data_out = 1,0,1,1.
- Reset mid-frame: assert rst after 2 bits of 4'b1111.
  - out_valid, data_out and the markers go 0 immediately (asynchronous), with no clock edge required.
  - After release, a new word 4'b0001 transmits cleanly as 0,0,0,1.
- PISO_PARITY_EN defined:
  - 4'b1001 → 1,0,0,1,0 with frame_last on the 5th bit.
  - 4'b1011 → 1,0,1,1,1.
